mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_types_pkg.sv | 13 +
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word and the RAM handshake state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (icache/dcache) arbiter onto a single RAM port with
// data priority, anti-starvation for instruction fetch, and access timeout.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int    TIMEOUT_CYC = 64,
  parameter word_t ERR_WORD    = 32'hBAD1BAD1
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      merr
);

  typedef enum logic [1:0] {IDLE, IACC, DACC} arb_state_t;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC - 1);

  arb_state_t state_q;
  logic       ren_q;
  logic       wen_q;
  word_t      addr_q;
  word_t      store_q;
  logic [7:0] cnt_q;
  logic       merr_q;
  logic       last_d_q;

  logic  d_req;
  logic  in_acc;
  logic  req_live;
  logic  ram_ok;
  logic  done;
  logic  err_done;
  word_t rd_data;

  assign d_req    = dREN | dWEN;
  assign in_acc   = (state_q != IDLE);
  assign req_live = (state_q == IACC) ? iREN : ((state_q == DACC) ? d_req : 1'b0);
  assign ram_ok   = (ramstate == ACCESS);
  // A dropped request aborts silently, even if the RAM answers that cycle.
  assign done     = in_acc && req_live &&
                    (ram_ok || (ramstate == ERROR) || (cnt_q == TO_LIM));
  assign err_done = done && !ram_ok;
  assign rd_data  = err_done ? ERR_WORD : (ren_q ? ramload : '0);

  assign iwait    = !(done && (state_q == IACC));
  assign dwait    = !(done && (state_q == DACC));
  assign iload    = (done && (state_q == IACC)) ? rd_data : '0;
  assign dload    = (done && (state_q == DACC)) ? rd_data : '0;

  assign ramREN   = ren_q;
  assign ramWEN   = wen_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign merr     = merr_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      store_q  <= '0;
      cnt_q    <= '0;
      merr_q   <= 1'b0;
      last_d_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Data wins unless it was served last and a fetch is waiting.
          if (d_req && !(last_d_q && iREN)) begin
            state_q <= DACC;
            addr_q  <= daddr;
            store_q <= dstore;
            ren_q   <= dREN;
            wen_q   <= dWEN;
            cnt_q   <= '0;
          end else if (iREN) begin
            state_q <= IACC;
            addr_q  <= iaddr;
            store_q <= '0;
            ren_q   <= 1'b1;
            wen_q   <= 1'b0;
            cnt_q   <= '0;
          end
        end
        default: begin
          if (!req_live || done) begin
            state_q <= IDLE;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            if (done)
              last_d_q <= (state_q == DACC);
            if (err_done)
              merr_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus timeout and reset sequences.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic      CLK;
  logic      nRST;
  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      merr;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.TIMEOUT_CYC(8), .ERR_WORD(32'hBAD1BAD1)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .merr(merr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic      iren;
    word_t     iaddr;
    logic      dren;
    logic      dwen;
    word_t     daddr;
    word_t     dstore;
    ramstate_t rs;
    word_t     rload;
    logic      e_iw;
    logic      e_dw;
    word_t     e_il;
    word_t     e_dl;
    logic      e_ren;
    logic      e_wen;
    word_t     e_addr;
    word_t     e_store;
    logic      e_merr;
  } vec_t;

  function automatic vec_t mk(logic ir, word_t ia, logic dr, logic dw, word_t da, word_t ds,
                              ramstate_t rs, word_t rl, logic eiw, logic edw, word_t eil,
                              word_t edl, logic eren, logic ewen, word_t eaddr, word_t estore,
                              logic emerr);
    vec_t v;
    v.iren = ir;  v.iaddr = ia;  v.dren = dr;  v.dwen = dw;
    v.daddr = da; v.dstore = ds; v.rs = rs;    v.rload = rl;
    v.e_iw = eiw; v.e_dw = edw;  v.e_il = eil; v.e_dl = edl;
    v.e_ren = eren; v.e_wen = ewen; v.e_addr = eaddr; v.e_store = estore;
    v.e_merr = emerr;
    return v;
  endfunction

  task automatic check1(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic idle_inputs();
    iREN = 0; iaddr = '0; dREN = 0; dWEN = 0; daddr = '0; dstore = '0;
    ramstate = FREE; ramload = '0;
  endtask

  vec_t vecs[24];

  initial begin
    logic [132:0] act, exp;
    int n;

    vecs[0]  = mk(0, 0,     0, 0, 0,     0,      FREE,   0,           1, 1, 0,           0,           0, 0, 0,     0,      0);
    vecs[1]  = mk(1, 'h40,  0, 0, 0,     0,      FREE,   0,           1, 1, 0,           0,           0, 0, 0,     0,      0);
    vecs[2]  = mk(1, 'h40,  0, 0, 0,     0,      BUSY,   0,           1, 1, 0,           0,           1, 0, 'h40,  0,      0);
    vecs[3]  = mk(1, 'h40,  0, 0, 0,     0,      ACCESS, 'h8C010000,  0, 1, 'h8C010000,  0,           1, 0, 'h40,  0,      0);
    vecs[4]  = mk(0, 0,     0, 0, 0,     0,      FREE,   0,           1, 1, 0,           0,           0, 0, 'h40,  0,      0);
    vecs[5]  = mk(1, 'h44,  0, 1, 'h100, 'hDEAD, FREE,   0,           1, 1, 0,           0,           0, 0, 'h40,  0,      0);
    vecs[6]  = mk(1, 'h44,  0, 1, 'h100, 'hDEAD, ACCESS, 'h12345678,  1, 0, 0,           0,           0, 1, 'h100, 'hDEAD, 0);
    vecs[7]  = mk(1, 'h44,  0, 0, 0,     0,      FREE,   0,           1, 1, 0,           0,           0, 0, 'h100, 'hDEAD, 0);
    vecs[8]  = mk(1, 'h44,  0, 0, 0,     0,      ACCESS, 'hAAAA0001,  0, 1, 'hAAAA0001,  0,           1, 0, 'h44,  0,      0);
    vecs[9]  = mk(0, 0,     0, 0, 0,     0,      FREE,   0,           1, 1, 0,           0,           0, 0, 'h44,  0,      0);
    vecs[10] = mk(1, 'h80,  1, 0, 'h200, 0,      FREE,   0,           1, 1, 0,           0,           0, 0, 'h44,  0,      0);
    vecs[11] = mk(1, 'h80,  1, 0, 'h200, 0,      ACCESS, 'h11110000,  1, 0, 0,           'h11110000,  1, 0, 'h200, 0,      0);
    vecs[12] = mk(1, 'h80,  1, 0, 'h200, 0,      FREE,   0,           1, 1, 0,           0,           0, 0, 'h200, 0,      0);
    vecs[13] = mk(1, 'h80,  1, 0, 'h200, 0,      ACCESS, 'h22220000,  0, 1, 'h22220000,  0,           1, 0, 'h80,  0,      0);
    vecs[14] = mk(1, 'h80,  1, 0, 'h200, 0,      FREE,   0,           1, 1, 0,           0,           0, 0, 'h80,  0,      0);
    vecs[15] = mk(1, 'h80,  1, 0, 'h200, 0,      ACCESS, 'h33330000,  1, 0, 0,           'h33330000,  1, 0, 'h200, 0,      0);
    vecs[16] = mk(0, 0,     0, 0, 0,     0,      FREE,   0,           1, 1, 0,           0,           0, 0, 'h200, 0,      0);
    vecs[17] = mk(1, 'h48,  0, 0, 0,     0,      FREE,   0,           1, 1, 0,           0,           0, 0, 'h200, 0,      0);
    vecs[18] = mk(1, 'h48,  0, 0, 0,     0,      BUSY,   0,           1, 1, 0,           0,           1, 0, 'h48,  0,      0);
    vecs[19] = mk(0, 'h48,  0, 0, 0,     0,      BUSY,   0,           1, 1, 0,           0,           1, 0, 'h48,  0,      0);
    vecs[20] = mk(0, 0,     0, 0, 0,     0,      FREE,   0,           1, 1, 0,           0,           0, 0, 'h48,  0,      0);
    vecs[21] = mk(0, 0,     1, 0, 'h300, 0,      FREE,   0,           1, 1, 0,           0,           0, 0, 'h48,  0,      0);
    vecs[22] = mk(0, 0,     1, 0, 'h300, 0,      ERROR,  'h55555555,  1, 0, 0,           'hBAD1BAD1,  1, 0, 'h300, 0,      0);
    vecs[23] = mk(0, 0,     0, 0, 0,     0,      FREE,   0,           1, 1, 0,           0,           0, 0, 'h300, 0,      1);

    idle_inputs();
    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < 24; i++) begin
      @(negedge CLK);
      iREN = vecs[i].iren;  iaddr = vecs[i].iaddr;
      dREN = vecs[i].dren;  dWEN = vecs[i].dwen;
      daddr = vecs[i].daddr; dstore = vecs[i].dstore;
      ramstate = vecs[i].rs; ramload = vecs[i].rload;
      #1;
      act = {iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, merr};
      exp = {vecs[i].e_iw, vecs[i].e_dw, vecs[i].e_il, vecs[i].e_dl, vecs[i].e_ren,
             vecs[i].e_wen, vecs[i].e_addr, vecs[i].e_store, vecs[i].e_merr};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL vec%0d: got %h want %h", i, act, exp);
      end else begin
        $display("ok   vec%0d: %h", i, act);
      end
    end

    // Reset clears the sticky error from the table's ERROR access.
    @(negedge CLK);
    idle_inputs();
    nRST = 1'b0;
    #1;
    check1("rst_merr", {31'd0, merr}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // RAM stuck BUSY: timeout must complete on the 8th access cycle.
    @(negedge CLK);
    dREN = 1; daddr = 'h400; ramstate = BUSY;
    #1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      #1;
      n++;
      if (!dwait) break;
    end
    check1("to_cycles", n, 8);
    check1("to_dload", dload, 32'hBAD1BAD1);
    @(negedge CLK);
    dREN = 0; ramstate = FREE;
    #1;
    check1("to_merr_set", {31'd0, merr}, 32'd1);
    check1("to_dwait_idle", {31'd0, dwait}, 32'd1);
    repeat (5) @(negedge CLK);
    #1;
    check1("to_merr_sticky", {31'd0, merr}, 32'd1);

    // Async reset in the middle of a write access.
    @(negedge CLK);
    dWEN = 1; daddr = 'h500; dstore = 'hBEEF; ramstate = BUSY;
    @(negedge CLK);
    #1;
    check1("rw_wen_before", {31'd0, ramWEN}, 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    check1("rw_wen_after", {31'd0, ramWEN}, 32'd0);
    check1("rw_dwait", {31'd0, dwait}, 32'd1);
    check1("rw_merr", {31'd0, merr}, 32'd0);
    check1("rw_addr", ramaddr, 32'd0);
    @(negedge CLK);
    idle_inputs();
    nRST = 1'b1;
    @(negedge CLK);
    #1;
    check1("rw_idle_ren", {30'd0, ramREN, ramWEN}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
